// File: rtl/i2c_controller_write.sv
// I2C initiator write engine: START, 7-bit address + W, data bytes with ACK checks, STOP.
// SCL/SDA open-drain enables are registered; SCL stretching freezes the quarter counter in Q2/Q3.
module i2c_controller_write #(
  parameter int DIV   = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  typedef enum logic [2:0] {
    IDLE, START, ADDR, ADDR_ACK, LOAD, DATA, DATA_ACK, STOP
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             last_q, last_d;
  logic             nack_q, nack_d;
  logic             done_q, done_d;
  logic             scl_oe_q, scl_oe_d;
  logic             sda_oe_q, sda_oe_d;
  logic             in_cell, stall, tick, cell_end;

  always_comb begin
    in_cell  = (state_q == ADDR) || (state_q == ADDR_ACK) ||
               (state_q == DATA) || (state_q == DATA_ACK);
    stall    = in_cell && qtr_q[1] && !scl_in;
    tick     = !stall && (cnt_q == CNT_MAX);
    cell_end = tick && (qtr_q == 2'd3);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    qtr_d    = qtr_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    last_d   = last_q;
    nack_d   = nack_q;
    done_d   = 1'b0;
    tx_ready = 1'b0;

    // Quarter timing runs in every state that owns bus time; IDLE and LOAD do not.
    if ((state_q inside {START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP}) && !stall) begin
      cnt_d = tick ? '0 : cnt_q + CNT_ONE;
      if (tick) qtr_d = qtr_q + 2'd1;
    end

    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = START;
        shift_d = {cmd_addr, 1'b0};
        nack_d  = 1'b0;
        cnt_d   = '0;
        qtr_d   = '0;
        bit_d   = '0;
      end
      START: if (tick && (qtr_q == 2'd1)) begin
        state_d = ADDR;
        qtr_d   = '0;
      end
      ADDR, DATA: if (cell_end) begin
        shift_d = {shift_q[6:0], 1'b0};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
      end
      ADDR_ACK: if (cell_end) begin
        if (sda_in) begin
          nack_d  = 1'b1;
          state_d = STOP;
        end else begin
          state_d = LOAD;
        end
      end
      LOAD: if (tx_valid) begin
        tx_ready = 1'b1;
        shift_d  = tx_data;
        last_d   = tx_last;
        state_d  = DATA;
        cnt_d    = '0;
        qtr_d    = '0;
        bit_d    = '0;
      end
      DATA_ACK: if (cell_end) begin
        if (sda_in) begin
          nack_d  = 1'b1;
          state_d = STOP;
        end else if (last_q) begin
          state_d = STOP;
        end else begin
          state_d = LOAD;
        end
      end
      STOP: if (cell_end) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Line enables follow the state/quarter being entered, so they change on quarter boundaries.
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    case (state_d)
      START: sda_oe_d = (qtr_d == 2'd1);
      ADDR, DATA: begin
        scl_oe_d = !qtr_d[1];
        sda_oe_d = !shift_d[7];
      end
      ADDR_ACK, DATA_ACK: scl_oe_d = !qtr_d[1];
      LOAD: begin
        scl_oe_d = 1'b1;
        sda_oe_d = sda_oe_q;
      end
      STOP: begin
        scl_oe_d = (qtr_d == 2'd0);
        sda_oe_d = !qtr_d[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      qtr_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      last_q   <= 1'b0;
      nack_q   <= 1'b0;
      done_q   <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      last_q   <= last_d;
      nack_q   <= nack_d;
      done_q   <= done_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign nack      = nack_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_i2c_controller_write.sv
// Bench for i2c_controller_write: an I2C target model decodes the open-drain bus and
// compares bytes, timing and handshakes against expectations computed from the protocol rules.
`timescale 1ns/1ps
module tb_i2c_controller_write;

  localparam int DIV  = 2;
  localparam int CELL = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = '0;
  logic       tx_last = 1'b0;
  logic       scl_oe, sda_oe, scl_in, sda_in;
  logic       busy, done, nack;

  int tests = 0;
  int fails = 0;

  // Target-side configuration (written by the tests) and state (written by the target model).
  logic       tgt_nack_addr = 1'b0;
  int         tgt_nack_byte = -1;
  logic       tgt_stretch_en = 1'b0;
  logic       tgt_clear = 1'b0;
  logic       tgt_sda = 1'b0;
  int         stretch_cnt = 0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1, cs, cd;
  logic       in_xfer = 1'b0, low_seen = 1'b0, stretch_done = 1'b0;
  int         bitcnt = 0, byte_idx = 0, ack_falls = 0, starts = 0, stops = 0;
  logic [7:0] shreg = '0;
  logic [7:0] rx_bytes [$];
  logic [7:0] txb [3];

  assign scl_in = !(scl_oe || (stretch_cnt != 0));
  assign sda_in = !(sda_oe || tgt_sda);

  i2c_controller_write #(.DIV(DIV), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl_in), .sda_in(sda_in),
    .busy(busy), .done(done), .nack(nack)
  );

  always #5 clk = ~clk;

  // I2C target: detects START/STOP, shifts bits on SCL rise, ACKs on the 9th clock, can stretch.
  always @(negedge clk) begin
    if (tgt_clear) begin
      in_xfer = 1'b0; bitcnt = 0; byte_idx = 0; ack_falls = 0; starts = 0; stops = 0;
      rx_bytes.delete(); stretch_done = 1'b0; stretch_cnt = 0; tgt_sda = 1'b0; low_seen = 1'b0;
    end
    if (stretch_cnt > 0) stretch_cnt--;
    if (tgt_stretch_en && !stretch_done && in_xfer && byte_idx == 0 && bitcnt == 3 &&
        low_seen && scl_oe === 1'b0) begin
      stretch_cnt  = 15;
      stretch_done = 1'b1;
    end
    cs = !(scl_oe || (stretch_cnt != 0));
    cd = !(sda_oe || tgt_sda);
    if (prev_scl && cs && prev_sda && !cd) begin
      in_xfer = 1'b1; bitcnt = 0; byte_idx = 0; starts++;
    end else if (prev_scl && cs && !prev_sda && cd) begin
      in_xfer = 1'b0; stops++;
    end else if (in_xfer && !prev_scl && cs) begin
      low_seen = 1'b0;
      if (bitcnt < 8) begin
        shreg = {shreg[6:0], cd};
        bitcnt++;
      end else if (bitcnt == 8) begin
        bitcnt = 9;
      end
    end else if (in_xfer && prev_scl && !cs) begin
      low_seen = 1'b1;
      if (bitcnt == 8) begin
        rx_bytes.push_back(shreg);
        tgt_sda = (byte_idx == 0) ? !tgt_nack_addr : ((byte_idx - 1) != tgt_nack_byte);
        byte_idx++;
      end else if (bitcnt == 9) begin
        tgt_sda = 1'b0;
        bitcnt = 0;
        ack_falls++;
      end
    end
    prev_scl = cs;
    prev_sda = cd;
  end

  task automatic clear_target();
    tgt_clear = 1'b1;
    @(negedge clk); #1;
    tgt_clear = 1'b0;
  endtask

  // One complete write transaction; expectations come from the protocol's bit/quarter budget.
  task automatic run_xfer(input string name, input logic [6:0] addr, input int n,
                          input logic na, input int nb, input int gap1, input logic st);
    logic [7:0] exp_b [$];
    int consumed, exp_len, pulses, cycles, gapc, idx, gap_bad;
    logic exp_nack, pend, finished, done_end, nack_end;
    exp_nack = na || (nb >= 0 && nb < n);
    if (na) consumed = 0;
    else if (nb >= 0 && nb < n) consumed = nb + 1;
    else consumed = n;
    exp_len = 2*DIV + 9*CELL + consumed*(1 + 9*CELL) + 4*DIV + (st ? 15 : 0)
              + ((consumed > 1) ? gap1 : 0);
    exp_b.push_back({addr, 1'b0});
    for (int i = 0; i < consumed; i++) exp_b.push_back(txb[i]);

    tgt_nack_addr = na; tgt_nack_byte = nb; tgt_stretch_en = st;
    clear_target();
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL %s cmd_ready_idle: got %b want 1", name, cmd_ready);
    end
    cmd_addr = addr; cmd_valid = 1'b1;
    tx_valid = 1'b1; tx_data = txb[0]; tx_last = (n == 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_addr = 7'($urandom);
    tests++;
    if (nack !== 1'b0) begin
      fails++; $display("FAIL %s nack_clear_on_accept: got %b want 0", name, nack);
    end

    pulses = 0; cycles = 0; gapc = 0; idx = 0; gap_bad = 0;
    pend = 1'b0; finished = 1'b0; done_end = 1'b0; nack_end = 1'b0;
    for (int c = 0; c < 20000 && !finished; c++) begin
      @(negedge clk); #1;
      if (!busy) begin
        finished = 1'b1; done_end = done; nack_end = nack;
      end else begin
        cycles++;
      end
      if (pend) begin idx++; pend = 1'b0; end
      tx_valid = 1'b0;
      if (idx < n) begin
        tx_data = txb[idx]; tx_last = (idx == n - 1);
        if (idx == 1 && gap1 > 0) begin
          if (gapc >= gap1) tx_valid = 1'b1;
          else if (ack_falls >= 2) begin
            gapc++;
            if (scl_oe !== 1'b1) gap_bad++;
          end
        end else begin
          tx_valid = 1'b1;
        end
      end
      #1;
      if (tx_ready === 1'b1) begin pulses++; pend = 1'b1; end
    end
    tx_valid = 1'b0;

    tests++;
    if (!finished) begin
      fails++; $display("FAIL %s timeout: busy still %b after 20000 cycles, want 0", name, busy);
    end
    tests++;
    if (cycles != exp_len) begin
      fails++; $display("FAIL %s length: got %0d cycles want %0d", name, cycles, exp_len);
    end
    tests++;
    if (done_end !== 1'b1) begin
      fails++; $display("FAIL %s done_pulse: got %b want 1", name, done_end);
    end
    tests++;
    if (nack_end !== exp_nack) begin
      fails++; $display("FAIL %s nack: got %b want %b", name, nack_end, exp_nack);
    end
    tests++;
    if (pulses != consumed) begin
      fails++; $display("FAIL %s tx_ready_pulses: got %0d want %0d", name, pulses, consumed);
    end
    tests++;
    if (starts != 1 || stops != 1) begin
      fails++; $display("FAIL %s start_stop: got %0d/%0d want 1/1", name, starts, stops);
    end
    tests++;
    if (rx_bytes.size() != exp_b.size()) begin
      fails++; $display("FAIL %s byte_count: got %0d want %0d", name, rx_bytes.size(), exp_b.size());
    end else begin
      for (int i = 0; i < exp_b.size(); i++) begin
        tests++;
        if (rx_bytes[i] !== exp_b[i]) begin
          fails++; $display("FAIL %s byte%0d: got %h want %h", name, i, rx_bytes[i], exp_b[i]);
        end
      end
    end
    if (consumed > 1 && gap1 > 0) begin
      tests++;
      if (gap_bad != 0 || gapc != gap1) begin
        fails++; $display("FAIL %s scl_low_gap: got %0d released of %0d want 0 of %0d",
                          name, gap_bad, gapc, gap1);
      end
    end
    @(negedge clk); #1;
    tests++;
    if (done !== 1'b0 || nack !== exp_nack) begin
      fails++; $display("FAIL %s after_done: got done=%b nack=%b want 0/%b", name, done, nack, exp_nack);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b1; tx_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    tests++;
    if ({scl_oe, sda_oe, busy, done, nack, tx_ready, cmd_ready} !== 7'b0000001) begin
      fails++; $display("FAIL reset_state: got %b want 0000001",
                        {scl_oe, sda_oe, busy, done, nack, tx_ready, cmd_ready});
    end
    cmd_valid = 1'b0; tx_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk); #1;
    tests++;
    if (busy !== 1'b0 || scl_oe !== 1'b0) begin
      fails++; $display("FAIL reset_idle_hold: got busy=%b scl_oe=%b want 0/0", busy, scl_oe);
    end
  endtask

  task automatic test_single_byte();
    txb[0] = 8'hA5;
    run_xfer("single", 7'h50, 1, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_addr_nack();
    txb[0] = 8'h3C;
    run_xfer("addr_nack", 7'h50, 1, 1'b1, -1, 0, 1'b0);
    txb[0] = 8'h96;
    run_xfer("after_nack", 7'h51, 1, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_gap();
    txb[0] = 8'h01; txb[1] = 8'h02; txb[2] = 8'h03;
    run_xfer("gap", 7'h22, 3, 1'b0, -1, 20, 1'b0);
  endtask

  task automatic test_data_nack();
    txb[0] = 8'h5A; txb[1] = 8'hFF;
    run_xfer("data_nack", 7'h33, 2, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_stretch();
    txb[0] = 8'h6E;
    run_xfer("stretch", 7'h7B, 1, 1'b0, -1, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic hit;
    tgt_nack_addr = 1'b0; tgt_nack_byte = -1; tgt_stretch_en = 1'b0;
    clear_target();
    cmd_addr = 7'h2A; cmd_valid = 1'b1;
    tx_valid = 1'b1; tx_data = 8'hC3; tx_last = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(negedge clk); #1;
      if (byte_idx == 1 && ack_falls == 1 && bitcnt == 4 && scl_oe === 1'b1) hit = 1'b1;
    end
    tests++;
    if (!hit) begin
      fails++; $display("FAIL reset_mid_reach: got no DATA bit 4 in 2000 cycles, want reached");
    end
    rst_n = 1'b0;
    @(negedge clk); #1;
    tests++;
    if ({scl_oe, sda_oe, busy, cmd_ready, done} !== 5'b00010) begin
      fails++; $display("FAIL reset_mid_release: got %b want 00010",
                        {scl_oe, sda_oe, busy, cmd_ready, done});
    end
    rst_n = 1'b1; tx_valid = 1'b0;
    @(negedge clk); #1;
    txb[0] = 8'h81; txb[1] = 8'h7E;
    run_xfer("post_reset", 7'h2A, 2, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [6:0] a;
    int n, nb, gap;
    logic na;
    for (int t = 0; t < 4; t++) begin
      a   = 7'($urandom);
      n   = $urandom_range(1, 3);
      na  = ($urandom_range(0, 4) == 0);
      nb  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      gap = $urandom_range(0, 10);
      for (int i = 0; i < 3; i++) txb[i] = 8'($urandom);
      run_xfer($sformatf("random%0d", t), a, n, na, nb, gap, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_addr_nack();
    test_gap();
    test_data_nack();
    test_stretch();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
